// File: rtl/rv_fetch.sv
`default_nettype none
// ============================================================================
// Module      : rv_fetch
// Description : RV32I instruction fetch stage. Issues in-order word reads to
//               instruction memory, buffers returned words with their PCs in
//               a small FIFO and presents the head to the execute datapath.
//               A redirect flushes buffered and in-flight fetches.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready
);

    // Pointer width and counter width (counters must hold 0..DEPTH inclusive)
    localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cw = c_aw + 1;
    localparam logic [c_cw:0] c_depth = (c_cw + 1)'(DEPTH);

    logic [31:0]     r_pc;
    logic [31:0]     r_rsp_pc;
    logic [31:0]     r_fifo_pc   [DEPTH];
    logic [31:0]     r_fifo_data [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_cw-1:0] r_count;
    logic [c_cw-1:0] r_inflight;
    logic [c_cw-1:0] r_drop;

    logic [31:0]     w_target;
    logic [c_cw:0]   w_credit;
    logic            w_req_fire;
    logic            w_rsp_legal;
    logic            w_push;
    logic            w_pop;
    logic            w_unused_bits;

    // Word-align the redirect target; the two low bits carry no meaning
    assign w_target      = {redirect_pc[31:2], 2'b00};
    assign w_unused_bits = ^redirect_pc[1:0];

    // Outstanding requests plus buffered words never exceed the FIFO size,
    // so every live response is guaranteed a free slot
    assign w_credit       = {1'b0, r_inflight} + {1'b0, r_count};
    assign imem_req_valid = reset && !redirect_valid && (w_credit < c_depth);
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored
    assign w_rsp_legal = reset && imem_rsp_valid && (r_inflight != '0);
    assign w_push      = w_rsp_legal && (r_drop == '0) && !redirect_valid;
    assign w_pop       = instr_valid && instr_ready && !redirect_valid;

    // Head of the FIFO drives the consumer; NOP and PC 0 when empty
    assign instr_valid = (r_count != '0);
    assign instr       = instr_valid ? r_fifo_data[r_rd_ptr] : NOP;
    assign instr_pc    = instr_valid ? r_fifo_pc[r_rd_ptr]   : 32'h0;

    // PC generation, FIFO pointers and in-flight / discard bookkeeping
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc       <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_drop     <= '0;
        end else if (redirect_valid) begin
            // Everything still outstanding after this edge belongs to the
            // abandoned stream and must be discarded on arrival
            r_pc       <= w_target;
            r_rsp_pc   <= w_target;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= r_inflight - c_cw'(w_rsp_legal);
            r_drop     <= r_inflight - c_cw'(w_rsp_legal);
        end else begin
            if (w_req_fire) begin
                r_pc <= r_pc + 32'd4;
            end
            if (w_push) begin
                r_rsp_pc <= r_rsp_pc + 32'd4;
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            r_count    <= r_count + c_cw'(w_push) - c_cw'(w_pop);
            r_inflight <= r_inflight + c_cw'(w_req_fire) - c_cw'(w_rsp_legal);
            if (w_rsp_legal && (r_drop != '0)) begin
                r_drop <= r_drop - c_cw'(1);
            end
        end
    end

    // FIFO storage: capture live responses with the PC they were fetched from
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]   <= r_rsp_pc;
            r_fifo_data[r_wr_ptr] <= imem_rsp_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_fetch
// Description : Self-checking bench for rv_fetch. A queue-based memory model
//               with random latency/backpressure feeds the DUT; consumed
//               instructions are compared against the expected sequential
//               program stream starting at each reset / redirect target.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_fetch;

    localparam logic [31:0] c_reset_pc = 32'h0000_0000;
    localparam logic [31:0] c_nop      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    rv_fetch #(
        .RESET_PC (c_reset_pc),
        .DEPTH    (4),
        .NOP      (c_nop)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          ready_pct = 100;
    int          cons_pct  = 100;
    int          lat_min   = 1;
    int          lat_max   = 1;
    int          last_due  = 0;
    logic        rst_drive = 1'b0;
    logic        redir_now = 1'b0;
    logic [31:0] redir_target = 32'h0;

    rsp_t        rsp_q[$];
    logic [31:0] req_q[$];
    logic [63:0] got_q[$];

    logic        obs_req_valid;
    logic        obs_acc;
    logic [31:0] obs_addr;
    logic        obs_instr_valid;
    logic [31:0] obs_instr;
    logic [31:0] obs_instr_pc;

    // Program image: three known instructions at the bottom, hashed words elsewhere
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0060_0093;
            32'h0000_0004: return 32'h0070_0113;
            32'h0000_0008: return 32'h4020_8133;
            default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    // One clock cycle: drive inputs at negedge, then observe and update models
    task automatic step();
        int lat;
        int due;
        @(negedge clk);
        cyc++;
        reset          = rst_drive;
        imem_req_ready = ($urandom_range(0, 99) < ready_pct);
        instr_ready    = ($urandom_range(0, 99) < cons_pct);
        redirect_valid = redir_now;
        redirect_pc    = redir_target;
        redir_now      = 1'b0;
        if (!rst_drive) begin
            rsp_q.delete();
            last_due = 0;
        end
        if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(rsp_q[0].addr);
            rsp_q.delete(0);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        obs_req_valid   = imem_req_valid;
        obs_acc         = imem_req_valid && imem_req_ready;
        obs_addr        = imem_req_addr;
        obs_instr_valid = instr_valid;
        obs_instr       = instr;
        obs_instr_pc    = instr_pc;
        if (obs_acc) begin
            lat = $urandom_range(lat_min, lat_max);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            rsp_q.push_back('{imem_req_addr, due});
            req_q.push_back(imem_req_addr);
        end
        if (instr_valid && instr_ready && !redirect_valid && rst_drive) begin
            got_q.push_back({instr_pc, instr});
        end
    endtask

    // Hold reset for two cycles; release takes effect on the next step
    task automatic do_reset();
        rst_drive = 1'b0;
        repeat (2) step();
        rst_drive = 1'b1;
        got_q.delete();
        req_q.delete();
    endtask

    task automatic test_reset();
        ready_pct = 100; cons_pct = 100; lat_min = 1; lat_max = 1;
        rst_drive = 1'b0;
        repeat (3) step();
        total++; if (obs_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid: got %b want 0", obs_req_valid); end
        total++; if (obs_addr !== c_reset_pc) begin bad++; $display("FAIL reset_req_addr: got %h want %h", obs_addr, c_reset_pc); end
        total++; if (obs_instr_valid !== 1'b0) begin bad++; $display("FAIL reset_instr_valid: got %b want 0", obs_instr_valid); end
        total++; if (obs_instr !== c_nop) begin bad++; $display("FAIL reset_instr: got %h want %h", obs_instr, c_nop); end
        total++; if (obs_instr_pc !== 32'h0) begin bad++; $display("FAIL reset_instr_pc: got %h want 0", obs_instr_pc); end
    endtask

    task automatic test_first_fetch();
        logic found;
        int   n;
        got_q.delete(); req_q.delete();
        rst_drive = 1'b1;
        found = 1'b0; n = 0;
        while (!found && n < 6) begin
            step();
            n++;
            if (obs_acc) found = 1'b1;
        end
        total++; if (!found) begin bad++; $display("FAIL first_req: no request accepted within %0d cycles", n); end
        total++; if (obs_addr !== c_reset_pc) begin bad++; $display("FAIL first_req_addr: got %h want %h", obs_addr, c_reset_pc); end
        step();
        total++; if (obs_instr_valid !== 1'b0 || obs_instr !== c_nop || obs_instr_pc !== 32'h0) begin
            bad++; $display("FAIL first_empty: got v=%b instr=%h pc=%h want v=0 instr=%h pc=0", obs_instr_valid, obs_instr, obs_instr_pc, c_nop);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (obs_instr_valid !== 1'b1 || obs_instr_pc !== 32'(4 * i) || obs_instr !== mem_word(32'(4 * i))) begin
                bad++; $display("FAIL first_seq[%0d]: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                                i, obs_instr_valid, obs_instr_pc, obs_instr, 32'(4 * i), mem_word(32'(4 * i)));
            end
        end
        total++;
        if (req_q.size() < 3) begin
            bad++; $display("FAIL first_req_count: got %0d want >=3", req_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (req_q[i] !== 32'(4 * i)) begin
                    bad++; $display("FAIL first_req_addr[%0d]: got %h want %h", i, req_q[i], 32'(4 * i));
                end
            end
        end
    endtask

    task automatic test_stall();
        int moved;
        do_reset();
        lat_min = 1; lat_max = 1; ready_pct = 100; cons_pct = 0;
        moved = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (obs_instr_valid && (obs_instr_pc !== 32'h0 || obs_instr !== 32'h0060_0093)) moved++;
        end
        total++; if (moved != 0) begin bad++; $display("FAIL stall_head_stable: head changed in %0d cycles want 0", moved); end
        total++; if (obs_instr_valid !== 1'b1 || obs_instr_pc !== 32'h0 || obs_instr !== 32'h0060_0093) begin
            bad++; $display("FAIL stall_head: got v=%b pc=%h instr=%h want v=1 pc=0 instr=00600093", obs_instr_valid, obs_instr_pc, obs_instr);
        end
        total++; if (obs_req_valid !== 1'b0) begin bad++; $display("FAIL stall_req_valid: got %b want 0", obs_req_valid); end
        total++; if (req_q.size() != 4) begin bad++; $display("FAIL stall_buffered: got %0d requests want 4", req_q.size()); end
        cons_pct = 100;
        repeat (12) step();
        total++;
        if (got_q.size() < 8) begin
            bad++; $display("FAIL stall_drain_count: got %0d want >=8", got_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (got_q[i] !== {32'(4 * i), mem_word(32'(4 * i))}) begin
                    bad++; $display("FAIL stall_drain[%0d]: got %h want %h", i, got_q[i], {32'(4 * i), mem_word(32'(4 * i))});
                end
            end
        end
    endtask

    task automatic test_redirect_inflight();
        int n;
        do_reset();
        lat_min = 3; lat_max = 3; ready_pct = 100; cons_pct = 100;
        n = 0;
        while (rsp_q.size() < 2 && n < 8) begin step(); n++; end
        total++; if (rsp_q.size() != 2) begin bad++; $display("FAIL redir_setup: got %0d in flight want 2", rsp_q.size()); end
        redir_now = 1'b1; redir_target = 32'h0000_0103;
        step();
        total++; if (obs_req_valid !== 1'b0) begin bad++; $display("FAIL redir_withdraw: got req_valid=%b want 0", obs_req_valid); end
        got_q.delete();
        step();
        total++; if (obs_acc !== 1'b1 || obs_addr !== 32'h100) begin
            bad++; $display("FAIL redir_first_req: got acc=%b addr=%h want acc=1 addr=00000100", obs_acc, obs_addr);
        end
        total++; if (obs_instr_valid !== 1'b0) begin bad++; $display("FAIL redir_flush: got instr_valid=%b want 0", obs_instr_valid); end
        repeat (14) step();
        total++;
        if (got_q.size() < 5) begin
            bad++; $display("FAIL redir_count: got %0d want >=5", got_q.size());
        end else begin
            for (int i = 0; i < got_q.size(); i++) begin
                if (got_q[i] !== {32'h100 + 32'(4 * i), mem_word(32'h100 + 32'(4 * i))}) begin
                    bad++; $display("FAIL redir_seq[%0d]: got %h want %h", i, got_q[i], {32'h100 + 32'(4 * i), mem_word(32'h100 + 32'(4 * i))});
                end
            end
        end
    endtask

    task automatic test_redirect_pop_push();
        do_reset();
        lat_min = 1; lat_max = 1; ready_pct = 100; cons_pct = 100;
        repeat (8) step();
        redir_now = 1'b1; redir_target = 32'h0000_0200;
        step();
        total++; if (obs_instr_valid !== 1'b1) begin bad++; $display("FAIL rpp_pre_valid: got %b want 1", obs_instr_valid); end
        got_q.delete();
        step();
        total++; if (obs_instr_valid !== 1'b0 || obs_instr !== c_nop || obs_instr_pc !== 32'h0) begin
            bad++; $display("FAIL rpp_flush: got v=%b instr=%h pc=%h want v=0 instr=%h pc=0", obs_instr_valid, obs_instr, obs_instr_pc, c_nop);
        end
        repeat (10) step();
        total++;
        if (got_q.size() < 5) begin
            bad++; $display("FAIL rpp_count: got %0d want >=5", got_q.size());
        end else begin
            for (int i = 0; i < got_q.size(); i++) begin
                if (got_q[i] !== {32'h200 + 32'(4 * i), mem_word(32'h200 + 32'(4 * i))}) begin
                    bad++; $display("FAIL rpp_seq[%0d]: got %h want %h", i, got_q[i], {32'h200 + 32'(4 * i), mem_word(32'h200 + 32'(4 * i))});
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int n0;
        do_reset();
        lat_min = 2; lat_max = 2; ready_pct = 100; cons_pct = 100;
        repeat (10) step();
        rst_drive = 1'b0;
        step();
        rst_drive = 1'b1;
        got_q.delete(); req_q.delete();
        step();
        total++; if (obs_instr_valid !== 1'b0) begin bad++; $display("FAIL mrst_valid: got %b want 0", obs_instr_valid); end
        total++; if (obs_acc !== 1'b1 || obs_addr !== c_reset_pc) begin
            bad++; $display("FAIL mrst_req: got acc=%b addr=%h want acc=1 addr=%h", obs_acc, obs_addr, c_reset_pc);
        end
        repeat (10) step();
        n0 = got_q.size();
        repeat (15) step();
        total++; if (got_q.size() - n0 != 15) begin bad++; $display("FAIL mrst_rate: got %0d instr in 15 cycles want 15", got_q.size() - n0); end
        total++;
        for (int i = 0; i < got_q.size(); i++) begin
            if (got_q[i] !== {c_reset_pc + 32'(4 * i), mem_word(c_reset_pc + 32'(4 * i))}) begin
                bad++; $display("FAIL mrst_seq[%0d]: got %h want %h", i, got_q[i], {c_reset_pc + 32'(4 * i), mem_word(c_reset_pc + 32'(4 * i))});
                break;
            end
        end
    endtask

    task automatic test_throughput();
        int n0;
        ready_pct = 100; cons_pct = 100;
        for (int lat = 1; lat <= 2; lat++) begin
            lat_min = lat; lat_max = lat;
            redir_now = 1'b1; redir_target = 32'h0000_0400 * 32'(lat);
            step();
            got_q.delete();
            repeat (8) step();
            n0 = got_q.size();
            repeat (20) step();
            total++; if (got_q.size() - n0 != 20) begin
                bad++; $display("FAIL tput_lat%0d: got %0d instr in 20 cycles want 20", lat, got_q.size() - n0);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] target;
        logic [31:0] exp_pc;
        int          len;
        lat_min = 1; lat_max = 4; ready_pct = 70; cons_pct = 60;
        for (int seg = 0; seg < 6; seg++) begin
            target = $urandom & 32'h0000_FFFF;
            redir_now = 1'b1; redir_target = target;
            step();
            got_q.delete(); req_q.delete();
            len = $urandom_range(40, 90);
            repeat (len) step();
            total++; if (got_q.size() == 0) begin bad++; $display("FAIL rand_progress[%0d]: got 0 instr want >0", seg); end
            exp_pc = target & 32'hFFFF_FFFC;
            for (int i = 0; i < req_q.size(); i++) begin
                total++;
                if (req_q[i] !== exp_pc + 32'(4 * i)) begin
                    bad++; $display("FAIL rand_req[%0d.%0d]: got %h want %h", seg, i, req_q[i], exp_pc + 32'(4 * i));
                end
            end
            for (int i = 0; i < got_q.size(); i++) begin
                total++;
                if (got_q[i] !== {exp_pc, mem_word(exp_pc)}) begin
                    bad++; $display("FAIL rand_seq[%0d.%0d]: got %h want %h", seg, i, got_q[i], {exp_pc, mem_word(exp_pc)});
                end
                exp_pc = exp_pc + 32'd4;
            end
        end
    endtask

    initial begin
        reset          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
        test_reset();
        test_first_fetch();
        test_stall();
        test_redirect_inflight();
        test_redirect_pop_push();
        test_mid_reset();
        test_throughput();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rv_fetch.md
# rv_fetch

Instruction fetch stage for the RV32I core. Generates the PC, issues in-order word reads to instruction memory over a valid/ready request channel, buffers returned words with their PCs in a small FIFO, and presents them to the `org` execute datapath as `instr` with a valid/ready handshake. A redirect input (branch/jump) flushes buffered and in-flight fetches and restarts at a new PC.

## Interface
- `RESET_PC`, 32'h0000_0000, PC of first fetch after reset
- `DEPTH`, 4, fetch FIFO entries; power of two, ≥2
- `NOP`, 32'h0000_0013, value driven on `instr` when FIFO empty (addi x0,x0,0)

- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-low (0 = reset, sampled on `clk`)
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_ready`  in  1  memory accepts request
- `imem_req_addr`  out  32  word address (bits [1:0] always 0)
- `imem_rsp_valid`  in  1  response word valid (in order, one per accepted request)
- `imem_rsp_data`  in  32  response instruction word
- `redirect_valid`  in  1  control-flow redirect, one-cycle pulse
- `redirect_pc`  in  32  redirect target; bits [1:0] ignored (forced 0)
- `instr`  out  32  head instruction to `org`; `NOP` when empty
- `instr_pc`  out  32  PC of head instruction; 0 when empty
- `instr_valid`  out  1  FIFO non-empty
- `instr_ready`  in  1  consumer takes head

## Operation
- State: `pc` (next request addr), `rsp_pc` (PC of next live response), FIFO of {pc, word}, `inflight` (accepted, not yet responded), `drop` (inflight responses to discard, ≤ `inflight`).
- Request: `imem_req_valid = reset && !redirect_valid && (inflight + count < DEPTH)`; `imem_req_addr = pc`. On valid&ready: `pc <= pc + 4` (mod 2^32), `inflight++`.
- While valid && !ready, `imem_req_addr` holds; a redirect withdraws the request (memory tolerates withdrawal).
- Response: if `drop > 0` or `redirect_valid` this cycle → discard, `drop--` (if >0). Else push {`rsp_pc`, data}, `rsp_pc <= rsp_pc + 4`. Every response does `inflight--`.
- Credit rule guarantees a live response always finds FIFO space; no overflow path exists. `imem_rsp_valid` with `inflight == 0` is a protocol error, ignored.
- Pop: `instr_valid && instr_ready` removes head.
- Redirect: `pc <= rsp_pc <= {redirect_pc[31:2],2'b00}`; FIFO flushed (count 0); `drop <= inflight - imem_rsp_valid` (all still-outstanding). Redirect overrides a simultaneous pop, push and request.
- Simultaneous accept and response in one cycle: `inflight` unchanged.
- Reset: `pc = rsp_pc = RESET_PC`, FIFO empty, `inflight = drop = 0`. Memory shares `reset`; responses during reset ignored. Reset mid-operation abandons all in-flight state.

## Timing
- Reset outputs: `imem_req_valid=0`, `imem_req_addr=RESET_PC`, `instr_valid=0`, `instr=NOP`, `instr_pc=0`.
- First request: cycle after `reset` deasserts (high at sampling edge).
- `instr`, `instr_pc`, `instr_valid` are FIFO-head registers; response at edge N → `instr_valid` visible cycle N+1. No combinational rsp→instr path.
- Request→instr latency = memory latency + 1 cycle.
- Sustained 1 instr/cycle with DEPTH=4 and memory latency ≤2 cycles, consumer always ready.
- Redirect at edge N: first request to target in cycle N+1; `instr_valid=0` from cycle N+1 until target word returns.
- `instr_ready` low holds head stable; FIFO fills to DEPTH, then requests stop.

## Test plan
- Reset release, 1-cycle memory, ready=1 → requests 0x0,0x4,0x8…; `instr_pc` 0x0 with `instr_valid` 2 cycles after first request; then one instr/cycle.
- Memory returns 0x00600093, 0x00700113, 0x40208133 at 0x0/0x4/0x8 → `instr` presents exactly that sequence, PCs 0x0/0x4/0x8, `NOP` between when empty.
- `instr_ready=0` for 10 cycles → exactly 4 entries buffered, `imem_req_valid` low, head stays 0x0/0x00600093; release → drains in order, no loss or duplicate.
- Redirect to 0x103 with 2 responses in flight (3-cycle memory) → both discarded, next request addr 0x100, first `instr_pc` 0x100, no stale word ever valid.
- Redirect in same cycle as pop and live response → neither pushed nor popped word survives; `instr_valid=0` next cycle.
- `reset` low mid-stream for 1 cycle → next request addr `RESET_PC`, `instr_valid=0`, `inflight`/`drop` zero.
